mux_4x1_trans: RTL and testbench

MUX_4X1_TRANS -- requirements
Module: mux_4x1_trans

---
 rtl/mux_4x1_trans_if.sv | 23 ++
 rtl/mux_4x1_trans.sv | 60 ++++++
 tb/tb_mux_4x1_trans.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mux_4x1_trans_if.sv
// rtl/mux_4x1_trans_if.sv - data/select/result bundle for mux_4x1_trans
interface mux_4x1_trans_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] result;
    logic [3:0]       sel_onehot;

    modport master (
        output d0, d1, d2, d3, s0, s1,
        input  result, sel_onehot
    );

    modport slave (
        input  d0, d1, d2, d3, s0, s1,
        output result, sel_onehot
    );
endinterface

// File: rtl/mux_4x1_trans.sv
// rtl/mux_4x1_trans.sv - 4:1 mux with registered one-hot select; MUX_4X1_TRANS_COMB_OUT_EN makes result combinational
module mux_4x1_trans #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux_4x1_trans_if.slave bus
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_out;
    logic [3:0]       onehot_next;
    logic [3:0]       sel_onehot_q;

    assign sel = {bus.s1, bus.s0};

    // Every select code is listed, so neither case can hold a previous value.
    always_comb begin
        case (sel)
            2'b00: mux_out = bus.d0;
            2'b01: mux_out = bus.d1;
            2'b10: mux_out = bus.d2;
            2'b11: mux_out = bus.d3;
        endcase
    end

    always_comb begin
        case (sel)
            2'b00: onehot_next = 4'b0001;
            2'b01: onehot_next = 4'b0010;
            2'b10: onehot_next = 4'b0100;
            2'b11: onehot_next = 4'b1000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_onehot_q <= 4'b0000;
        end else begin
            sel_onehot_q <= onehot_next;
        end
    end

    assign bus.sel_onehot = sel_onehot_q;

`ifdef MUX_4X1_TRANS_COMB_OUT_EN
    assign bus.result = mux_out;
`else
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= mux_out;
        end
    end

    assign bus.result = result_q;
`endif
endmodule

// File: tb/tb_mux_4x1_trans.sv
// tb/tb_mux_4x1_trans.sv - scoreboard bench for mux_4x1_trans at WIDTH=1 and WIDTH=8
module tb_mux_4x1_trans;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_4x1_trans_if #(.WIDTH(1)) bus1 ();
    mux_4x1_trans_if #(.WIDTH(8)) bus8 ();

    mux_4x1_trans #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mux_4x1_trans #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct packed {
        logic [7:0] r8;
        logic       r1;
        logic [3:0] oh;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef MUX_4X1_TRANS_COMB_OUT_EN
    localparam bit COMB = 1'b1;
`else
    localparam bit COMB = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: pick d[sel] from an array, one-hot is a shift of 1 by the select.
    task automatic drive_push(input logic r, input logic [1:0] s,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] dv [4];
        exp_t e;
        dv[0] = a0; dv[1] = a1; dv[2] = a2; dv[3] = a3;
        rst = r;
        {bus1.s1, bus1.s0} = s;
        {bus8.s1, bus8.s0} = s;
        bus1.d0 = a0[0]; bus1.d1 = a1[0]; bus1.d2 = a2[0]; bus1.d3 = a3[0];
        bus8.d0 = a0;    bus8.d1 = a1;    bus8.d2 = a2;    bus8.d3 = a3;
        e.r8 = (r && !COMB) ? 8'h00 : dv[s];
        e.r1 = e.r8[0];
        e.oh = r ? 4'b0000 : (4'b0001 << s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic r, input logic [1:0] s,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
        @(negedge clk);
        drive_push(r, s, a0, a1, a2, a3);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result_w1", {31'd0, bus1.result}, {31'd0, e.r1});
            check("result_w8", {24'd0, bus8.result}, {24'd0, e.r8});
            check("onehot_w1", {28'd0, bus1.sel_onehot}, {28'd0, e.oh});
            check("onehot_w8", {28'd0, bus8.sel_onehot}, {28'd0, e.oh});
        end
    end

    initial begin
        logic [5:0] v;
        bus1.d0 = '0; bus1.d1 = '0; bus1.d2 = '0; bus1.d3 = '0; bus1.s0 = 0; bus1.s1 = 0;
        bus8.d0 = '0; bus8.d1 = '0; bus8.d2 = '0; bus8.d3 = '0; bus8.s0 = 0; bus8.s1 = 0;

        apply(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(1'b1, 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        for (int i = 0; i < 64; i++) begin
            v = i[5:0];
            apply(1'b0, v[5:4], {7'd0, v[0]}, {7'd0, v[1]}, {7'd0, v[2]}, {7'd0, v[3]});
        end

        for (int i = 0; i < 4; i++) begin
            v = i[5:0];
            apply(1'b0, v[1:0], 8'h01, 8'h00, 8'h01, 8'h00);
        end

        apply(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
        apply(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
        apply(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);

        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 2'b10, i[0] ? 8'hFF : 8'h00, i[1] ? 8'hFF : 8'h00, 8'h00,
                  i[0] ? 8'h00 : 8'hFF);
        end

        apply(1'b0, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00);

`ifdef MUX_4X1_TRANS_COMB_OUT_EN
        @(negedge clk);
        rst = 1'b0;
        bus1.d0 = 1'b0; bus1.d3 = 1'b1; {bus1.s1, bus1.s0} = 2'b00;
        #1;
        check("comb_sel00", {31'd0, bus1.result}, 32'd0);
        {bus1.s1, bus1.s0} = 2'b11;
        #1;
        check("comb_sel11", {31'd0, bus1.result}, 32'd1);
        drive_push(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
`endif

        for (int i = 0; i < 200; i++) begin
            apply(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
